// File: rtl/fetch_queue_unit.sv
// Fetch stage with an I-cache request/response handshake, in-order in-flight PC tracking and a
// small PC/instruction queue toward decode. Redirects flush the queue and drop late responses.
module fetch_queue_unit #(
   parameter int unsigned         XLEN            = 32,
   parameter logic [XLEN-1:0]     RESET_PC        = 32'h1000,
   parameter logic [XLEN-1:0]     EXC_PC          = 32'h2000,
   parameter int unsigned         QDEPTH          = 4,
   parameter int unsigned         MAX_OUTSTANDING = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       exc_occured_i,
   input  logic                       iret_i,
   input  logic [XLEN-1:0]            exc_return_pc_i,
   input  logic                       bp_error_i,
   input  logic                       alu_branch_i,
   input  logic                       alu_jumps_i,
   input  logic [XLEN-1:0]            alu_pc_jmp_i,
   input  logic [XLEN-1:0]            alu_pc_no_jmp_i,
   input  logic                       jal_i,
   input  logic [XLEN-1:0]            jal_pc_i,
   input  logic                       bp_taken_i,
   input  logic [XLEN-1:0]            bp_pred_pc_i,
   output logic                       ic_req_valid_o,
   output logic [XLEN-1:0]            ic_req_addr_o,
   input  logic                       ic_req_ready_i,
   input  logic                       ic_rsp_valid_i,
   input  logic [XLEN-1:0]            ic_rsp_data_i,
   output logic                       dec_valid_o,
   output logic [XLEN-1:0]            dec_pc_o,
   output logic [XLEN-1:0]            dec_instr_o,
   input  logic                       dec_ready_i,
   output logic [$clog2(QDEPTH):0]    q_count_o
);

   localparam int unsigned QAW = $clog2(QDEPTH);
   localparam int unsigned CW  = QAW + 1;
   localparam int unsigned OAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SW  = ((CW > OCW) ? CW : OCW) + 1;
   localparam logic [OCW-1:0] MAX_O  = OCW'(MAX_OUTSTANDING);
   localparam logic [OAW-1:0] IF_LAST = OAW'(MAX_OUTSTANDING - 1);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] q_pc_q [QDEPTH];
   logic [XLEN-1:0] q_pc_d [QDEPTH];
   logic [XLEN-1:0] q_ins_q [QDEPTH];
   logic [XLEN-1:0] q_ins_d [QDEPTH];
   logic [QAW-1:0]  q_rd_q, q_rd_d, q_wr_q, q_wr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] if_pc_q [MAX_OUTSTANDING];
   logic [XLEN-1:0] if_pc_d [MAX_OUTSTANDING];
   logic [OAW-1:0]  if_rd_q, if_rd_d, if_wr_q, if_wr_d;
   logic [OCW-1:0]  out_q, out_d, drop_q, drop_d;

   logic            redirect, req_hs, pop, push;
   logic [XLEN-1:0] target;
   logic [SW-1:0]   credit;

   always_comb begin
      redirect = exc_occured_i | iret_i | bp_error_i | jal_i;
      if (exc_occured_i) begin
         target = EXC_PC;
      end else if (iret_i) begin
         target = exc_return_pc_i;
      end else if (bp_error_i) begin
         target = (alu_branch_i & alu_jumps_i) ? alu_pc_jmp_i : alu_pc_no_jmp_i;
      end else begin
         target = jal_pc_i;
      end

      // Entries already promised to the queue: occupied plus responses that will be kept.
      credit         = SW'(count_q) + SW'(out_q) - SW'(drop_q);
      ic_req_valid_o = !rst_i && !redirect && (out_q < MAX_O) && (credit < SW'(QDEPTH));
      ic_req_addr_o  = fetch_pc_q;
      req_hs         = ic_req_valid_o & ic_req_ready_i;

      dec_valid_o = (count_q != '0) && !redirect && !rst_i;
      dec_pc_o    = q_pc_q[q_rd_q];
      dec_instr_o = q_ins_q[q_rd_q];
      q_count_o   = rst_i ? '0 : count_q;
      pop         = dec_valid_o & dec_ready_i;
      push        = ic_rsp_valid_i && !redirect && (drop_q == '0);

      fetch_pc_d = fetch_pc_q;
      q_pc_d     = q_pc_q;
      q_ins_d    = q_ins_q;
      q_rd_d     = q_rd_q;
      q_wr_d     = q_wr_q;
      if_pc_d    = if_pc_q;
      if_rd_d    = if_rd_q;
      if_wr_d    = if_wr_q;
      drop_d     = drop_q;

      if (req_hs) begin
         if_pc_d[if_wr_q] = fetch_pc_q;
         if_wr_d          = (if_wr_q == IF_LAST) ? '0 : if_wr_q + OAW'(1);
         fetch_pc_d       = bp_taken_i ? bp_pred_pc_i : fetch_pc_q + XLEN'(4);
      end
      if (ic_rsp_valid_i) begin
         if_rd_d = (if_rd_q == IF_LAST) ? '0 : if_rd_q + OAW'(1);
         if (!redirect && (drop_q != '0)) begin
            drop_d = drop_q - OCW'(1);
         end
      end
      out_d = out_q + OCW'(req_hs) - OCW'(ic_rsp_valid_i);

      if (push) begin
         q_pc_d[q_wr_q]  = if_pc_q[if_rd_q];
         q_ins_d[q_wr_q] = ic_rsp_data_i;
         q_wr_d          = q_wr_q + QAW'(1);
      end
      if (pop) begin
         q_rd_d = q_rd_q + QAW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      if (redirect) begin
         fetch_pc_d = target;
         q_rd_d     = '0;
         q_wr_d     = '0;
         count_d    = '0;
         drop_d     = out_q - OCW'(ic_rsp_valid_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         q_rd_q     <= '0;
         q_wr_q     <= '0;
         count_q    <= '0;
         if_rd_q    <= '0;
         if_wr_q    <= '0;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         q_rd_q     <= q_rd_d;
         q_wr_q     <= q_wr_d;
         count_q    <= count_d;
         if_rd_q    <= if_rd_d;
         if_wr_q    <= if_wr_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

   // Storage needs no reset; validity is tracked by the counters and pointers.
   always_ff @(posedge clk_i) begin
      q_pc_q  <= q_pc_d;
      q_ins_q <= q_ins_d;
      if_pc_q <= if_pc_d;
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus random traffic, all
// compared against a queue-based reference model and a simple in-order cache model.
module tb_fetch_queue_unit;

   localparam int QDEPTH = 4;
   localparam int MAXO   = 2;

   logic        clk = 1'b0;
   logic        rst, exc, iret, bperr, alu_br, alu_j, jal, bp_taken, ic_ready, rsp_v, dec_ready;
   logic [31:0] iret_pc, alu_pj, alu_pnj, jal_pc, bp_pred, rsp_d;
   logic        ic_req_valid_o, dec_valid_o;
   logic [31:0] ic_req_addr_o, dec_pc_o, dec_instr_o;
   logic [2:0]  q_count_o;

   fetch_queue_unit #(
      .XLEN(32), .RESET_PC(32'h1000), .EXC_PC(32'h2000), .QDEPTH(QDEPTH), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk_i(clk), .rst_i(rst), .exc_occured_i(exc), .iret_i(iret), .exc_return_pc_i(iret_pc),
      .bp_error_i(bperr), .alu_branch_i(alu_br), .alu_jumps_i(alu_j), .alu_pc_jmp_i(alu_pj),
      .alu_pc_no_jmp_i(alu_pnj), .jal_i(jal), .jal_pc_i(jal_pc), .bp_taken_i(bp_taken),
      .bp_pred_pc_i(bp_pred), .ic_req_valid_o(ic_req_valid_o), .ic_req_addr_o(ic_req_addr_o),
      .ic_req_ready_i(ic_ready), .ic_rsp_valid_i(rsp_v), .ic_rsp_data_i(rsp_d),
      .dec_valid_o(dec_valid_o), .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o),
      .dec_ready_i(dec_ready), .q_count_o(q_count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_infl[$];
   logic [31:0] pend[$];
   logic [31:0] req_log[$];
   logic [31:0] dec_log[$];
   int          req_cyc[$];
   int          dec_cyc[$];
   int          m_drop;
   logic [31:0] m_fetch;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          rsp_pct  = 100;
   int          cyc      = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clear_logs();
      req_log.delete();
      dec_log.delete();
      req_cyc.delete();
      dec_cyc.delete();
   endtask

   task automatic quiet();
      rst = 0; exc = 0; iret = 0; bperr = 0; alu_br = 0; alu_j = 0; jal = 0; bp_taken = 0;
   endtask

   // One clock cycle: drive response, check outputs, advance model. Entered and left at negedge.
   task automatic step();
      logic        redir, e_req, e_dv, hs, keep;
      logic [31:0] hs_addr, tgt;
      ent_t        e;
      rsp_v = (pend.size() > 0) && ($urandom_range(99) < rsp_pct);
      rsp_d = rsp_v ? mem(pend[0]) : 32'h0;
      #1;
      redir = exc | iret | bperr | jal;
      e_req = !rst && !redir && (m_infl.size() < MAXO) &&
              ((mq.size() + m_infl.size() - m_drop) < QDEPTH);
      e_dv  = !rst && !redir && (mq.size() > 0);
      check("req_valid", 32'(ic_req_valid_o), 32'(e_req));
      if (e_req) check("req_addr", ic_req_addr_o, m_fetch);
      check("dec_valid", 32'(dec_valid_o), 32'(e_dv));
      if (e_dv) begin
         check("dec_pc", dec_pc_o, mq[0].pc);
         check("dec_instr", dec_instr_o, mq[0].ins);
      end
      check("q_count", 32'(q_count_o), rst ? 32'd0 : 32'(mq.size()));
      hs      = ic_req_valid_o && ic_ready;
      hs_addr = ic_req_addr_o;
      if (hs) begin
         req_log.push_back(hs_addr);
         req_cyc.push_back(cyc);
      end
      if (dec_valid_o && dec_ready) begin
         dec_log.push_back(dec_pc_o);
         dec_cyc.push_back(cyc);
      end
      @(posedge clk);
      keep = 1'b0;
      e    = '0;
      if (rst) begin
         m_fetch = 32'h1000;
         m_infl.delete();
         mq.delete();
         m_drop = 0;
      end else begin
         if (rsp_v) begin
            if (m_infl.size() == 0) begin
               check("rsp_with_none_outstanding", 32'd0, 32'd1);
            end else begin
               e.pc  = m_infl.pop_front();
               e.ins = rsp_d;
               if (!redir) begin
                  if (m_drop > 0) m_drop--;
                  else keep = 1'b1;
               end
            end
         end
         if (redir) begin
            if (exc) tgt = 32'h2000;
            else if (iret) tgt = iret_pc;
            else if (bperr) tgt = (alu_br && alu_j) ? alu_pj : alu_pnj;
            else tgt = jal_pc;
            mq.delete();
            m_drop  = m_infl.size();
            m_fetch = tgt;
         end else begin
            if (e_dv && dec_ready) void'(mq.pop_front());
            if (keep) mq.push_back(e);
            if (e_req && ic_ready) begin
               m_infl.push_back(m_fetch);
               m_fetch = bp_taken ? bp_pred : m_fetch + 32'd4;
            end
         end
      end
      if (rsp_v) void'(pend.pop_front());
      if (rst) pend.delete();
      else if (hs) pend.push_back(hs_addr);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      quiet();
      rst = 1; iret_pc = 0; alu_pj = 0; alu_pnj = 0; jal_pc = 0; bp_pred = 0;
      ic_ready = 1; dec_ready = 1; rsp_v = 0; rsp_d = 0;
      m_fetch = 32'h1000; m_drop = 0;
      @(negedge clk);

      // Reset, then streaming with an always-ready cache and decoder.
      step(); step();
      check("rst_q_count", 32'(q_count_o), 32'd0);
      check("rst_req_valid", 32'(ic_req_valid_o), 32'd0);
      clear_logs();
      rst = 0;
      repeat (8) step();
      check("first_req", req_log[0], 32'h1000);
      check("second_req", req_log[1], 32'h1004);
      check("first_dec", dec_log[0], 32'h1000);
      check("second_dec", dec_log[1], 32'h1004);
      check("dec_latency", 32'(dec_cyc[0] - req_cyc[0]), 32'd2);

      // Decoder stall fills the queue, then drains in order.
      dec_ready = 0;
      repeat (10) step();
      check("full_count", 32'(q_count_o), 32'd4);
      check("full_no_req", 32'(ic_req_valid_o), 32'd0);
      clear_logs();
      dec_ready = 1;
      repeat (12) step();
      check("drain_count", 32'(dec_log.size() >= 8), 32'd1);
      for (int i = 1; i < dec_log.size(); i++) check("drain_seq", dec_log[i] - dec_log[i-1], 32'd4);

      // Predicted-taken request at 0x1008 redirects fetch to 0x3000.
      jal = 1; jal_pc = 32'h1008;
      step();
      quiet();
      clear_logs();
      bp_taken = 1; bp_pred = 32'h3000;
      for (int i = 0; i < 5 && m_fetch == 32'h1008; i++) step();
      bp_taken = 0;
      repeat (6) step();
      check("bp_req0", req_log[0], 32'h1008);
      check("bp_req1", req_log[1], 32'h3000);
      check("bp_dec0", dec_log[0], 32'h1008);
      check("bp_dec1", dec_log[1], 32'h3000);

      // Mispredict with two requests in flight: both late responses dropped.
      rsp_pct = 0;
      for (int i = 0; i < 6 && m_infl.size() < 2; i++) step();
      check("two_outstanding", 32'(m_infl.size()), 32'd2);
      bperr = 1; alu_br = 1; alu_j = 0; alu_pnj = 32'h1010; alu_pj = 32'h5550;
      step();
      quiet();
      clear_logs();
      rsp_pct = 100;
      repeat (8) step();
      check("bperr_req", req_log[0], 32'h1010);
      check("bperr_dec", dec_log[0], 32'h1010);

      // Simultaneous redirects: exception wins; then iret alone.
      exc = 1; iret = 1; iret_pc = 32'h1400; jal = 1; jal_pc = 32'h1800;
      step();
      quiet();
      clear_logs();
      repeat (3) step();
      check("exc_prio", req_log[0], 32'h2000);
      iret = 1;
      step();
      quiet();
      clear_logs();
      repeat (3) step();
      check("iret_req", req_log[0], 32'h1400);

      // Reset with queue occupied and a response arriving in the reset cycle.
      dec_ready = 0;
      for (int i = 0; i < 8 && mq.size() < 2; i++) step();
      rsp_pct = 0;
      for (int i = 0; i < 6 && m_infl.size() < 2; i++) step();
      rsp_pct = 100;
      rst = 1;
      step();
      rst = 0;
      dec_ready = 1;
      check("post_rst_count", 32'(q_count_o), 32'd0);
      check("post_rst_dec_valid", 32'(dec_valid_o), 32'd0);
      clear_logs();
      repeat (3) step();
      check("post_rst_req", req_log[0], 32'h1000);

      // Fetch PC wraps modulo 2^32.
      jal = 1; jal_pc = 32'hFFFF_FFFC;
      step();
      quiet();
      clear_logs();
      repeat (5) step();
      check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
      check("wrap_req1", req_log[1], 32'h0000_0000);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(199) == 0);
         exc       = ($urandom_range(99) < 2);
         iret      = ($urandom_range(99) < 2);
         bperr     = ($urandom_range(99) < 3);
         jal       = ($urandom_range(99) < 3);
         alu_br    = $urandom_range(1);
         alu_j     = $urandom_range(1);
         iret_pc   = $urandom() & ~32'h3;
         alu_pj    = $urandom() & ~32'h3;
         alu_pnj   = $urandom() & ~32'h3;
         jal_pc    = $urandom() & ~32'h3;
         bp_taken  = ($urandom_range(99) < 20);
         bp_pred   = $urandom() & ~32'h3;
         ic_ready  = ($urandom_range(99) < 70);
         dec_ready = ($urandom_range(99) < 60);
         rsp_pct   = 50;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
